// File: rtl/esitleme_eslestirici_pkg.sv
// Shared constants for the equalization remap stage: state encodings and
// default widths of the pixel index and the histogram-stage table word.
package esitleme_eslestirici_pkg;

  localparam int PIXEL_BIT_VARS     = 8;
  localparam int LUT_GIRIS_BIT_VARS = 24;

  localparam logic [1:0] ES_BOS   = 2'd0;
  localparam logic [1:0] ES_YUKLE = 2'd1;
  localparam logic [1:0] ES_HAZIR = 2'd2;

endpackage

// File: rtl/esitleme_eslestirici.sv
// Captures the streamed equalization table, then remaps a pixel stream through it
// with a valid/ready handshake; the global stall freezes every register.
module esitleme_eslestirici
  import esitleme_eslestirici_pkg::*;
#(
  parameter int PIXEL_BIT     = PIXEL_BIT_VARS,
  parameter int LUT_GIRIS_BIT = LUT_GIRIS_BIT_VARS
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     stal_i,
  input  logic                     lut_gecerli_i,
  input  logic [LUT_GIRIS_BIT-1:0] lut_deger_i,
  input  logic                     pixel_gecerli_i,
  input  logic [PIXEL_BIT-1:0]     pixel_i,
  output logic                     pixel_hazir_o,
  output logic                     sonuc_gecerli_o,
  output logic [PIXEL_BIT-1:0]     sonuc_o,
  input  logic                     sonuc_hazir_i,
  output logic                     tablo_yuklu_o,
  output logic                     tablo_tamam_o
);

  localparam int                   TABLO_DERINLIK = 1 << PIXEL_BIT;
  localparam logic [PIXEL_BIT-1:0] SON_ADRES      = {PIXEL_BIT{1'b1}};
  localparam logic [PIXEL_BIT-1:0] BIR            = {{(PIXEL_BIT-1){1'b0}}, 1'b1};

  logic [1:0]           durum_q, durum_d;
  logic [PIXEL_BIT-1:0] yaz_adres_q, yaz_adres_d;
  logic                 tamam_q, tamam_d;
  logic [PIXEL_BIT-1:0] sonuc_q, sonuc_d;
  logic                 sonuc_gecerli_q, sonuc_gecerli_d;
  logic [PIXEL_BIT-1:0] tablo_q [TABLO_DERINLIK];
  logic                 yakala_s, kabul_s;

  // Entries wider than a pixel clamp to full white instead of wrapping.
  function automatic logic [PIXEL_BIT-1:0] doygun(input logic [LUT_GIRIS_BIT-1:0] deger);
    logic [PIXEL_BIT-1:0] dar;
    if (|deger[LUT_GIRIS_BIT-1:PIXEL_BIT]) begin
      dar = {PIXEL_BIT{1'b1}};
    end else begin
      dar = deger[PIXEL_BIT-1:0];
    end
    return dar;
  endfunction

  // A held hazir_o during stall must not be captured twice.
  assign yakala_s      = lut_gecerli_i && !stal_i;
  assign pixel_hazir_o = (durum_q == ES_HAZIR) && !lut_gecerli_i &&
                         (!sonuc_gecerli_q || sonuc_hazir_i) && !stal_i;
  assign kabul_s       = pixel_gecerli_i && pixel_hazir_o;

  always_comb begin
    durum_d         = durum_q;
    yaz_adres_d     = yaz_adres_q;
    tamam_d         = 1'b0;
    sonuc_d         = sonuc_q;
    sonuc_gecerli_d = sonuc_gecerli_q;
    if (yakala_s) begin
      yaz_adres_d = yaz_adres_q + BIR;
      case (durum_q)
        ES_YUKLE: begin
          if (yaz_adres_q == SON_ADRES) begin
            durum_d = ES_HAZIR;
            tamam_d = 1'b1;
          end else begin
            durum_d = ES_YUKLE;
          end
        end
        default: durum_d = ES_YUKLE;
      endcase
    end else begin
      yaz_adres_d = yaz_adres_q;
    end
    if (kabul_s) begin
      sonuc_d         = tablo_q[pixel_i];
      sonuc_gecerli_d = 1'b1;
    end else if (sonuc_hazir_i && !stal_i) begin
      sonuc_gecerli_d = 1'b0;
    end else begin
      sonuc_gecerli_d = sonuc_gecerli_q;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      durum_q         <= ES_BOS;
      yaz_adres_q     <= {PIXEL_BIT{1'b0}};
      tamam_q         <= 1'b0;
      sonuc_q         <= {PIXEL_BIT{1'b0}};
      sonuc_gecerli_q <= 1'b0;
    end else if (!stal_i) begin
      durum_q         <= durum_d;
      yaz_adres_q     <= yaz_adres_d;
      tamam_q         <= tamam_d;
      sonuc_q         <= sonuc_d;
      sonuc_gecerli_q <= sonuc_gecerli_d;
    end
  end

  // Table storage; reset clears it so a partial load never leaks stale entries.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < TABLO_DERINLIK; i++) begin
        tablo_q[i] <= {PIXEL_BIT{1'b0}};
      end
    end else if (yakala_s) begin
      tablo_q[yaz_adres_q] <= doygun(lut_deger_i);
    end
  end

  assign sonuc_o         = sonuc_q;
  assign sonuc_gecerli_o = sonuc_gecerli_q;
  assign tablo_yuklu_o   = (durum_q == ES_HAZIR);
  assign tablo_tamam_o   = tamam_q;

endmodule

// File: tb/tb_esitleme_eslestirici.sv
// Self-checking bench for esitleme_eslestirici: table-driven pixel vectors, directed
// corner sequences and random traffic, all checked against a behavioural table model.
module tb_esitleme_eslestirici;

  logic        clk = 1'b0;
  logic        rstn_i, stal_i, lut_gecerli_i, pixel_gecerli_i, sonuc_hazir_i;
  logic [23:0] lut_deger_i;
  logic [7:0]  pixel_i, sonuc_o;
  logic        pixel_hazir_o, sonuc_gecerli_o, tablo_yuklu_o, tablo_tamam_o;

  esitleme_eslestirici dut (
    .clk_i(clk), .rstn_i(rstn_i), .stal_i(stal_i),
    .lut_gecerli_i(lut_gecerli_i), .lut_deger_i(lut_deger_i),
    .pixel_gecerli_i(pixel_gecerli_i), .pixel_i(pixel_i),
    .pixel_hazir_o(pixel_hazir_o), .sonuc_gecerli_o(sonuc_gecerli_o),
    .sonuc_o(sonuc_o), .sonuc_hazir_i(sonuc_hazir_i),
    .tablo_yuklu_o(tablo_yuklu_o), .tablo_tamam_o(tablo_tamam_o)
  );

  always #5 clk = ~clk;

  int toplam = 0;
  int hata = 0;
  int tamam_sayac = 0;

  // reference model: the table as seen by the mapper, plus load progress
  int unsigned m_tablo [256];
  int          m_adres;
  bit          m_yuklu, m_tamam, m_out_v;
  int unsigned m_out;
  logic [23:0] degerler [256];

  typedef struct {
    logic [7:0] piksel;
    logic [7:0] beklenen;
  } vektor_t;
  vektor_t vektorler [6];

  task automatic kontrol(input string ad, input logic [31:0] gercek, input logic [31:0] beklenen);
    toplam++;
    if (gercek !== beklenen) begin
      hata++;
      $display("FAIL %s: actual %0h required %0h at %0t", ad, gercek, beklenen, $time);
    end
  endtask

  function automatic int unsigned sat(input logic [23:0] v);
    return (v > 24'd255) ? 255 : int'(v);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 256; i++) m_tablo[i] = 0;
    m_adres = 0; m_yuklu = 0; m_tamam = 0; m_out_v = 0; m_out = 0;
  endtask

  // One clock cycle: called just after a falling edge, returns just after the next one.
  task automatic adim(input logic lv, input logic [23:0] ld, input logic pv,
                      input logic [7:0] p, input logic rdy, input logic st);
    bit hazir_bek, cap, acc;
    lut_gecerli_i = lv; lut_deger_i = ld; pixel_gecerli_i = pv;
    pixel_i = p; sonuc_hazir_i = rdy; stal_i = st;
    #1;
    hazir_bek = m_yuklu && !lv && (!m_out_v || rdy) && !st;
    kontrol("pixel_hazir", {31'd0, pixel_hazir_o}, {31'd0, hazir_bek});
    cap = lv && !st;
    acc = pv && hazir_bek;
    @(posedge clk);
    if (!st) begin
      m_tamam = 0;
      if (acc) begin
        m_out = m_tablo[p]; m_out_v = 1;
      end else if (rdy) begin
        m_out_v = 0;
      end
      if (cap) begin
        m_tablo[m_adres] = sat(ld);
        m_adres++;
        m_yuklu = 0;
        if (m_adres == 256) begin
          m_adres = 0; m_yuklu = 1; m_tamam = 1;
        end
      end
    end
    @(negedge clk);
    kontrol("sonuc_gecerli", {31'd0, sonuc_gecerli_o}, {31'd0, m_out_v});
    kontrol("sonuc", {24'd0, sonuc_o}, m_out);
    kontrol("tablo_yuklu", {31'd0, tablo_yuklu_o}, {31'd0, m_yuklu});
    kontrol("tablo_tamam", {31'd0, tablo_tamam_o}, {31'd0, m_tamam});
    if (tablo_tamam_o) tamam_sayac++;
  endtask

  task automatic yukle_dizi();
    for (int i = 0; i < 256; i++) adim(1'b1, degerler[i], 1'b0, 8'd0, 1'b1, 1'b0);
  endtask

  task automatic piksel_oku(input logic [7:0] p, input logic [7:0] beklenen, input string ad);
    adim(1'b0, 24'd0, 1'b1, p, 1'b1, 1'b0);
    kontrol(ad, {24'd0, sonuc_o}, {24'd0, beklenen});
    kontrol("oku_gecerli", {31'd0, sonuc_gecerli_o}, 32'd1);
  endtask

  task automatic reset_kontrol(input string ad);
    kontrol(ad, {27'd0, pixel_hazir_o, sonuc_gecerli_o, tablo_yuklu_o, tablo_tamam_o, 1'b0}, 32'd0);
    kontrol("reset_sonuc", {24'd0, sonuc_o}, 32'd0);
  endtask

  initial begin
    vektorler[0] = '{8'd0,   8'd0};
    vektorler[1] = '{8'd17,  8'd17};
    vektorler[2] = '{8'd255, 8'd255};
    vektorler[3] = '{8'd128, 8'd128};
    vektorler[4] = '{8'd1,   8'd1};
    vektorler[5] = '{8'd254, 8'd254};

    rstn_i = 1'b0; stal_i = 1'b0; lut_gecerli_i = 1'b0; lut_deger_i = 24'd0;
    pixel_gecerli_i = 1'b0; pixel_i = 8'd0; sonuc_hazir_i = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    reset_kontrol("reset_cikis");
    rstn_i = 1'b1;
    adim(1'b0, 24'd0, 1'b1, 8'd3, 1'b1, 1'b0);

    // identity load, then table-driven back-to-back pixels
    for (int i = 0; i < 256; i++) degerler[i] = 24'(i);
    tamam_sayac = 0;
    yukle_dizi();
    kontrol("kimlik_tamam_sayisi", tamam_sayac, 32'd1);
    kontrol("kimlik_yuklu", {31'd0, tablo_yuklu_o}, 32'd1);
    for (int i = 0; i < 6; i++) begin
      adim(1'b0, 24'd0, 1'b1, vektorler[i].piksel, 1'b1, 1'b0);
      kontrol("vektor_sonuc", {24'd0, sonuc_o}, {24'd0, vektorler[i].beklenen});
      kontrol("vektor_gecerli", {31'd0, sonuc_gecerli_o}, 32'd1);
    end
    adim(1'b0, 24'd0, 1'b0, 8'd0, 1'b1, 1'b0);

    // random table with saturating entries, then random traffic
    for (int i = 0; i < 256; i++)
      degerler[i] = ($urandom_range(0, 3) == 0) ? 24'($urandom) : 24'($urandom_range(0, 255));
    degerler[5] = 24'h000123; degerler[6] = 24'h0000FE; degerler[10] = 24'd200;
    yukle_dizi();
    for (int i = 0; i < 300; i++)
      adim(1'b0, 24'd0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0));
    adim(1'b0, 24'd0, 1'b0, 8'd0, 1'b1, 1'b0);
    piksel_oku(8'd5, 8'd255, "doyma_5");
    piksel_oku(8'd6, 8'd254, "doyma_6");
    adim(1'b0, 24'd0, 1'b0, 8'd0, 1'b1, 1'b0);

    // backpressure: result held for 4 cycles, then one transfer
    adim(1'b0, 24'd0, 1'b1, 8'd10, 1'b0, 1'b0);
    kontrol("geri_basinc_ilk", {24'd0, sonuc_o}, 32'd200);
    for (int i = 0; i < 4; i++) begin
      adim(1'b0, 24'd0, 1'b1, 8'd3, 1'b0, 1'b0);
      kontrol("geri_basinc_sabit", {24'd0, sonuc_o}, 32'd200);
      kontrol("geri_basinc_hazir", {31'd0, pixel_hazir_o}, 32'd0);
    end
    adim(1'b0, 24'd0, 1'b0, 8'd0, 1'b1, 1'b0);
    kontrol("geri_basinc_aktarim", {31'd0, sonuc_gecerli_o}, 32'd0);

    // stall with hazir held high at entry 100
    for (int i = 0; i < 256; i++) degerler[i] = 24'((i * 7 + 3) % 256);
    tamam_sayac = 0;
    for (int i = 0; i < 256; i++) begin
      if (i == 100) repeat (3) adim(1'b1, degerler[i], 1'b0, 8'd0, 1'b1, 1'b1);
      if (i == 255) kontrol("durus_son_once", {31'd0, tablo_yuklu_o}, 32'd0);
      adim(1'b1, degerler[i], 1'b0, 8'd0, 1'b1, 1'b0);
    end
    kontrol("durus_tamam_sayisi", tamam_sayac, 32'd1);
    piksel_oku(8'd99,  8'((99 * 7 + 3) % 256),  "durus_99");
    piksel_oku(8'd100, 8'((100 * 7 + 3) % 256), "durus_100");
    piksel_oku(8'd101, 8'((101 * 7 + 3) % 256), "durus_101");
    adim(1'b0, 24'd0, 1'b0, 8'd0, 1'b1, 1'b0);

    // reload with an output pending from the old (all-7) table
    for (int i = 0; i < 256; i++) degerler[i] = 24'd7;
    yukle_dizi();
    adim(1'b0, 24'd0, 1'b1, 8'd42, 1'b0, 1'b0);
    for (int i = 0; i < 256; i++) begin
      adim(1'b1, 24'(i ^ 8'h5A), 1'b1, 8'(i), (i >= 3), 1'b0);
      if (i == 2) begin
        kontrol("yeniden_bekleyen", {24'd0, sonuc_o}, 32'd7);
        kontrol("yeniden_bekleyen_v", {31'd0, sonuc_gecerli_o}, 32'd1);
      end
      if (i == 3) kontrol("yeniden_teslim", {31'd0, sonuc_gecerli_o}, 32'd0);
    end
    piksel_oku(8'd0,   8'h5A,          "yeni_tablo_0");
    piksel_oku(8'h33,  8'h33 ^ 8'h5A,  "yeni_tablo_33");
    piksel_oku(8'hFF,  8'hFF ^ 8'h5A,  "yeni_tablo_ff");

    // reset after 50 entries of a new load
    for (int i = 0; i < 256; i++) degerler[i] = 24'(255 - i);
    for (int i = 0; i < 50; i++) adim(1'b1, 24'd99, 1'b0, 8'd0, 1'b0, 1'b0);
    rstn_i = 1'b0;
    #1;
    reset_kontrol("ara_reset");
    model_reset();
    @(negedge clk);
    rstn_i = 1'b1;
    for (int i = 0; i < 255; i++) adim(1'b1, degerler[i], 1'b0, 8'd0, 1'b1, 1'b0);
    kontrol("ara_reset_eksik", {31'd0, tablo_yuklu_o}, 32'd0);
    adim(1'b1, degerler[255], 1'b0, 8'd0, 1'b1, 1'b0);
    kontrol("ara_reset_yuklu", {31'd0, tablo_yuklu_o}, 32'd1);
    piksel_oku(8'd49, 8'd206, "ara_reset_49");
    piksel_oku(8'd0,  8'd255, "ara_reset_0");

    $display("End of test - %0d assertions evaluated, %0d failures", toplam, hata);
    $finish;
  end

endmodule

// File: doc/esitleme_eslestirici.md
# esitleme_eslestirici

Downstream stage of the histogram/equalization unit. Captures the 256-entry equalization table that the histogram stage streams out after each frame's histogram pass. Then remaps a grayscale pixel stream through that table with a valid/ready handshake and a one-cycle registered output. Honours the global `stal_i` freeze so it stays lock-step with the upstream stage.

## Interface
- `PIXEL_BIT`, default 8 (`` `PIXEL_BIT `` from `sabitler.vh`): pixel / table-index width; table depth = 2^PIXEL_BIT.
- `LUT_GIRIS_BIT`, default 24: width of the table-entry word delivered by the histogram stage.
- `clk_i`  in  1  single clock, all state on rising edge.
- `rstn_i`  in  1  reset, asynchronous and active-low.
- `stal_i`  in  1  global freeze; while high every register, including table storage, holds.
- `lut_gecerli_i`  in  1  table entry valid (histogram stage `hazir_o`).
- `lut_deger_i`  in  LUT_GIRIS_BIT  table entry value (histogram stage `pixel_o`).
- `pixel_gecerli_i`  in  1  input pixel valid.
- `pixel_i`  in  PIXEL_BIT  input grayscale pixel (table index).
- `pixel_hazir_o`  out  1  ready for input pixel.
- `sonuc_gecerli_o`  out  1  mapped pixel valid.
- `sonuc_o`  out  PIXEL_BIT  mapped pixel.
- `sonuc_hazir_i`  in  1  downstream ready.
- `tablo_yuklu_o`  out  1  a complete table is held (state HAZIR).
- `tablo_tamam_o`  out  1  one-cycle pulse when the last entry is written.

## Operation
- States:
  - BOS (reset, no table).
  - YUKLE (loading).
  - HAZIR (mapping).
- Table storage: 2^PIXEL_BIT x PIXEL_BIT register array plus a PIXEL_BIT-bit write counter `yaz_adres`.
- Entry capture is qualified with `lut_gecerli_i && !stal_i`. On capture, write `doygun(lut_deger_i)` to `tablo[yaz_adres]` and increment `yaz_adres`.
  - `doygun`: if any bit above PIXEL_BIT-1 is set, the value saturates to 2^PIXEL_BIT-1; otherwise the low PIXEL_BIT bits are used.
- BOS -> YUKLE on the first capture. That entry goes to index 0 and the counter becomes 1.
- HAZIR -> YUKLE on any capture. That entry goes to index 0 (the counter was 0), so a new frame's table overwrites the old one.
- YUKLE -> HAZIR on the capture with `yaz_adres == 2^PIXEL_BIT-1`. The counter wraps to 0 and `tablo_tamam_o` pulses in the next cycle.
- Handshake:
  - `pixel_hazir_o = (durum==HAZIR) && !lut_gecerli_i && (!sonuc_gecerli_o || sonuc_hazir_i) && !stal_i`.
  - A pixel is accepted when `pixel_gecerli_i && pixel_hazir_o`.
  - On accept, `sonuc_o <= tablo[pixel_i]` and `sonuc_gecerli_o <= 1`.
  - Otherwise, if `sonuc_hazir_i && !stal_i`, then `sonuc_gecerli_o <= 0`.
- An output held in `sonuc_o` when a reload starts stays valid and unchanged until consumed. It was mapped with the old table.
- Simultaneous capture and pixel: the capture wins and the pixel is not accepted (ready is low).
- `sonuc_o` must not change while `sonuc_gecerli_o && !sonuc_hazir_i`.

## Timing
- Reset (async assert, sync release) values:
  - state BOS, `yaz_adres` 0.
  - `pixel_hazir_o` 0, `sonuc_gecerli_o` 0, `sonuc_o` 0.
  - `tablo_yuklu_o` 0, `tablo_tamam_o` 0.
  - Table contents are cleared to 0.
- Reset mid-load returns to BOS. Entries already written are discarded and the next capture restarts at index 0.
- Latency: accept in cycle N gives `sonuc_gecerli_o` and `sonuc_o` in cycle N+1.
- Throughput: 1 pixel/cycle while `sonuc_hazir_i` stays high.
- Table load takes 2^PIXEL_BIT capture cycles, excluding stall cycles. `tablo_yuklu_o` rises in the cycle after the last capture, together with `tablo_tamam_o`.
- `stal_i` high: no state, counter, table or output change. `pixel_hazir_o` is forced low. `lut_gecerli_i` is ignored, since upstream holds `hazir_o` during a stall and it must not be written twice.

## Structure
- `sabitler.vh` gains state encodings `ES_BOS`, `ES_YUKLE`, `ES_HAZIR` and `TABLO_DERINLIK = 1<<PIXEL_BIT`.
- No sub-module required.
- The saturating narrowing is a local function, not a separate module.
- Table storage is an inferred register array, one read port (combinational index by `pixel_i`) and one write port.

## Test plan
- Identity load: stream entries 0..255 with values equal to their index, then send pixels 0, 17, 255 -> `tablo_tamam_o` pulses once and `tablo_yuklu_o`=1; outputs are 0, 17, 255, each one cycle after accept.
- Saturation: table with entry 5 = 24'h000123 and entry 6 = 24'h0000FE, then pixels 5 and 6 -> outputs 255 and 254.
- Backpressure: with the table loaded, send pixel 10 (table[10]=200) and hold `sonuc_hazir_i`=0 for 4 cycles -> `sonuc_o`=200 stable, `pixel_hazir_o`=0 throughout, then one transfer when ready rises.
- Stall during load: assert `stal_i` for 3 cycles at entry 100 with `lut_gecerli_i` held high -> entry 100 written exactly once, and the load still completes after 256 captures.
- Reload: with an old table (all 7) loaded, start a new load with a pending output -> the pending output is delivered as 7, no pixels are accepted during the load, and after completion outputs come from the new table.
- Reset mid-load: assert `rstn_i`=0 after 50 entries -> outputs return to reset values immediately, and a fresh 256-entry load is required before `tablo_yuklu_o`=1.
